s_array_init: RTL and testbench
===============================

# s_array_init

Start-pulse responder for the RC4 datapath: waits for the one-cycle `start` pulse issued by the power-up start sequencer, then fills the S-array working memory with the identity permutation (S[i] = i for i = 0..DEPTH-1) through a single-port write interface. When the last entry is written it returns a one-cycle `done` pulse and re-arms. It is the first task stage of the decryption pipeline; the key-scheduling stage consumes its `done`.

## Interface
- `DEPTH`, 256, number of S-array entries; power of two, ≥ 2.
- `ADDR_W`, $clog2(DEPTH), address and data width (derived; not overridden).

- `clk`  input  1  system clock; all logic on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request pulse; sampled only in IDLE.
- `busy`  output  1  high while writes are in progress.
- `done`  output  1  one-cycle completion pulse.
- `mem_addr`  output  ADDR_W  S-array write address.
- `mem_data`  output  ADDR_W  S-array write data; always equals `mem_addr`.
- `mem_wren`  output  1  write enable; one write per cycle while high.

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: `busy`=0, `done`=0, `mem_wren`=0, counter held at 0. `start`=1 → WRITE.
- WRITE: `mem_wren`=1, `busy`=1, `mem_addr`=`mem_data`=counter. Counter increments by 1 each cycle. When counter = DEPTH-1 (last write issued this cycle) → DONE; counter returns to 0 and never wraps inside WRITE.
- DONE: `done`=1, `busy`=0, `mem_wren`=0, for exactly one cycle → IDLE unconditionally.
- `start` in WRITE or DONE is ignored (not queued). Block is re-armable: any later `start` in IDLE repeats the full fill.
- All outputs registered: state bits and counter drive outputs directly; no combinational path from `start` to any output.
- Reset (`rst_n`=0, any time, async): state IDLE, counter 0, `busy`=0, `done`=0, `mem_wren`=0, `mem_addr`=`mem_data`=0. Reset mid-fill aborts immediately; memory holds a partial fill, no `done` is produced, a new `start` is required.

## Timing
- `start` high in IDLE at edge N → first write (addr 0) visible in cycle N+1.
- Writes occupy cycles N+1 .. N+DEPTH (DEPTH cycles, addr 0..DEPTH-1 in order, no gaps).
- `done`=1 in cycle N+DEPTH+1 only; IDLE from N+DEPTH+2; earliest accepted restart `start` at that edge.
- Start-to-done latency: DEPTH+1 cycles. `start` held high continuously → fills back-to-back with one IDLE cycle between `done` and the next first write.
- `busy` and `mem_wren` are identical waveforms; `busy` and `done` never both high.
- Counter arithmetic is ADDR_W-bit unsigned; terminal compare against DEPTH-1, not overflow.

## Structure
- Shared package `rc4_pkg`: state enum typedef (IDLE/WRITE/DONE), `S_DEPTH` = 256 constant, `S_ADDR_W` = 8; the key-scheduling and PRGA stages reuse these.
- Single flat module; address counter stays inline (no sub-module). Companion stages connect via the same `start`/`done` handshake.

## Test plan
- Reset then single `start` pulse at cycle 5 → writes addr/data 0..255 in cycles 6..261, `done` high only in cycle 262, `busy` high exactly 6..261.
- `start` pulses at cycles 10 and 100 (mid-fill) → second pulse ignored: exactly 256 writes, one `done`.
- `start` held high from cycle 3 onward → `done` at 260, first write of second fill at 262 (addr 0), sequence repeats.
- `rst_n` asserted asynchronously in cycle 50 of a fill → outputs 0 immediately, no `done`; next `start` restarts at addr 0.
- DEPTH=4 build, `start` at cycle 2 → writes 0,1,2,3 in cycles 3..6, `done` at 7, IDLE at 8.
- Scoreboard: model memory after `done` equals identity for every index; no write when `mem_wren`=0.

Source files
------------

// File: rtl/rc4_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rc4_pkg : shared constants and state encoding for the RC4 stages      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package rc4_pkg;

  localparam int S_DEPTH  = 256;
  localparam int S_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } rc4_state_e;

endpackage
`default_nettype wire

// File: rtl/s_array_init.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | s_array_init : fills the S-array with the identity permutation on     |
// | a start pulse, then returns a one-cycle done pulse and re-arms.        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module s_array_init
  import rc4_pkg::*;
#(
  parameter  int DEPTH  = S_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_data,
  output logic              mem_wren
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  rc4_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Terminal compare on LAST_IDX keeps the counter from relying on wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = WRITE;
      end
      WRITE: begin
        if (cnt_q == LAST_IDX) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q == WRITE);
  assign mem_wren = (state_q == WRITE);
  assign done     = (state_q == DONE);
  assign mem_addr = cnt_q;
  assign mem_data = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_s_array_init.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_s_array_init : scoreboard bench for s_array_init (DEPTH 256 and 4) |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_s_array_init;

  localparam int DEPTH = 256;

  typedef struct {
    int cyc;
    int addr;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, mem_wren;
  logic [7:0] mem_addr, mem_data;

  logic       start4 = 1'b0;
  logic       busy4, done4, mem_wren4;
  logic [1:0] mem_addr4, mem_data4;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int idle_from = 0;
  int model [DEPTH];
  wr_t wq [$];
  int  dq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  s_array_init #(.DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren)
  );

  s_array_init #(.DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .busy(busy4), .done(done4),
    .mem_addr(mem_addr4), .mem_data(mem_data4), .mem_wren(mem_wren4)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One stimulus cycle; an accepted start queues the whole expected fill.
  task automatic tick(input logic s);
    @(negedge clk);
    start = s;
    if (s && rst_n && cyc >= idle_from) begin
      for (int k = 0; k < DEPTH; k++) wq.push_back('{cyc + 1 + k, k});
      dq.push_back(cyc + DEPTH + 1);
      idle_from = cyc + DEPTH + 2;
      for (int i = 0; i < DEPTH; i++) model[i] = -1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy_eq_wren", int'(busy), int'(mem_wren));
      check("busy_and_done", int'(busy & done), 0);
      if (mem_wren) begin
        check("data_eq_addr", int'(mem_data), int'(mem_addr));
        if (wq.size() == 0) begin
          check("write_unexpected", 1, 0);
        end else begin
          wr_t e;
          e = wq.pop_front();
          check("write_cycle", cyc, e.cyc);
          check("write_addr", int'(mem_addr), e.addr);
        end
        model[mem_addr] = int'(mem_data);
      end else begin
        check("idle_addr", int'(mem_addr), 0);
      end
      if (done) begin
        if (dq.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          check("done_cycle", cyc, dq.pop_front());
          for (int i = 0; i < DEPTH; i++) check("identity", model[i], i);
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_wren"}, int'(mem_wren), 0);
    check({tag, "_addr"}, int'(mem_addr), 0);
    check({tag, "_data"}, int'(mem_data), 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_zero_outputs("reset");
    check("reset_wren4", int'(mem_wren4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_from = 0;

    // Single pulse after a few idle cycles
    repeat (4) tick(1'b0);
    tick(1'b1);
    repeat (DEPTH + 5) tick(1'b0);
    check("t1_wq_empty", wq.size(), 0);
    check("t1_dq_empty", dq.size(), 0);

    // Second pulse mid-fill must be ignored
    tick(1'b1);
    repeat (89) tick(1'b0);
    tick(1'b1);
    repeat (DEPTH + 5) tick(1'b0);
    check("t2_wq_empty", wq.size(), 0);
    check("t2_dq_empty", dq.size(), 0);

    // Start held high: back-to-back fills with one idle cycle between
    repeat (3 * DEPTH) tick(1'b1);
    repeat (DEPTH + 5) tick(1'b0);
    check("t3_wq_empty", wq.size(), 0);
    check("t3_dq_empty", dq.size(), 0);

    // Asynchronous reset mid-fill aborts; a new start restarts at 0
    tick(1'b1);
    repeat (50) tick(1'b0);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("async_rst");
    wq.delete();
    dq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle_from = cyc;
    repeat (3) tick(1'b0);
    tick(1'b1);
    repeat (DEPTH + 5) tick(1'b0);
    check("t4_wq_empty", wq.size(), 0);
    check("t4_dq_empty", dq.size(), 0);

    // DEPTH=4 instance: writes 0..3, done, then idle
    @(negedge clk);
    start4 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start4 = 1'b0;
      check("d4_wren", int'(mem_wren4), (k <= 4) ? 1 : 0);
      check("d4_busy", int'(busy4), (k <= 4) ? 1 : 0);
      check("d4_addr", int'(mem_addr4), (k <= 4) ? k - 1 : 0);
      check("d4_data", int'(mem_data4), (k <= 4) ? k - 1 : 0);
      check("d4_done", int'(done4), (k == 5) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
